// File: rtl/arb_memory.sv
// Unified word-organised RAM shared by a fetch port and a load/store port through a fair arbiter.
// Latency: response exactly READ_LATENCY cycles after the accepting edge; one accept per cycle in total.
// Backpressure: request side only (ready = grant); responses are single-cycle pulses with no backpressure.
//
// Ports:
//   clk, reset                         clock and asynchronous active-high reset
//   ivalid/iready/iaddr                fetch request handshake and byte address
//   irvalid/irdata/ierr                fetch response pulse, data, error flag
//   dvalid/dready/dwe/dstrb/daddr/dwdata  load/store request handshake, store enable, byte strobes, address, data
//   drvalid/drdata/derr                load/store response pulse, load data (0 for stores/errors), error flag
module arb_memory #(
    parameter int MEMORY_WORDS = 65536,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ivalid,
    output logic        iready,
    input  logic [31:0] iaddr,
    output logic        irvalid,
    output logic [31:0] irdata,
    output logic        ierr,
    input  logic        dvalid,
    output logic        dready,
    input  logic        dwe,
    input  logic [3:0]  dstrb,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    output logic        drvalid,
    output logic [31:0] drdata,
    output logic        derr
);

    localparam int AW = (MEMORY_WORDS > 1) ? $clog2(MEMORY_WORDS) : 1;
    localparam int LAST = READ_LATENCY - 1;

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("arb_memory: READ_LATENCY must be in 1..4");
    end

    logic [31:0] mem [MEMORY_WORDS];

    // Arbiter state: 1 when the fetch port won the most recent conflict.
    logic last_i_q, last_i_d;

    logic          grant_i;
    logic          grant_d;
    logic          acc_vld;
    logic [31:0]   acc_addr;
    logic [AW-1:0] acc_idx;
    logic          acc_err;
    logic          acc_store;
    logic [31:0]   acc_data;

    // Response pipeline; port bit is 1 for the load/store port.
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] port_q, port_d;
    logic [READ_LATENCY-1:0] err_q, err_d;
    logic [31:0]             data_q [READ_LATENCY];
    logic [31:0]             data_d [READ_LATENCY];

    always_comb begin
        grant_i   = ivalid && (!dvalid || !last_i_q);
        grant_d   = dvalid && !grant_i;
        iready    = !reset && grant_i;
        dready    = !reset && grant_d;
        acc_vld   = iready || dready;
        acc_addr  = grant_i ? iaddr : daddr;
        acc_idx   = acc_addr[AW+1:2];
        // Range check uses the full word index so high address bits cannot alias into the array.
        acc_err   = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= 32'(MEMORY_WORDS));
        acc_store = dready && dwe;
        // Read happens before this edge's write lands, so a store returns 0 rather than old data.
        acc_data  = (acc_err || acc_store) ? 32'h0 : mem[acc_idx];

        last_i_d = last_i_q;
        if (ivalid && dvalid && !reset) begin
            last_i_d = grant_i;
        end
    end

    always_comb begin
        vld_d  = '0;
        port_d = '0;
        err_d  = '0;
        for (int k = 0; k < READ_LATENCY; k++) begin
            data_d[k] = '0;
        end
        vld_d[0]  = acc_vld;
        port_d[0] = dready;
        err_d[0]  = acc_vld && acc_err;
        data_d[0] = acc_vld ? acc_data : 32'h0;
        for (int k = 1; k < READ_LATENCY; k++) begin
            vld_d[k]  = vld_q[k-1];
            port_d[k] = port_q[k-1];
            err_d[k]  = err_q[k-1];
            data_d[k] = data_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_i_q <= 1'b0;
            vld_q    <= '0;
            port_q   <= '0;
            err_q    <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            last_i_q <= last_i_d;
            vld_q    <= vld_d;
            port_q   <= port_d;
            err_q    <= err_d;
            for (int k = 0; k < READ_LATENCY; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // RAM is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge clk) begin
        if (acc_store && !acc_err) begin
            for (int n = 0; n < 4; n++) begin
                if (dstrb[n]) begin
                    mem[acc_idx][8*n +: 8] <= dwdata[8*n +: 8];
                end
            end
        end
    end

    always_comb begin
        irvalid = vld_q[LAST] && !port_q[LAST];
        drvalid = vld_q[LAST] && port_q[LAST];
        ierr    = irvalid && err_q[LAST];
        derr    = drvalid && err_q[LAST];
        irdata  = irvalid ? data_q[LAST] : 32'h0;
        drdata  = drvalid ? data_q[LAST] : 32'h0;
    end

endmodule

// File: tb/tb_arb_memory.sv
module tb_arb_memory;

    localparam int MW = 65536;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int compared = 0;
    int mismatched = 0;

    // DUT with READ_LATENCY=1
    logic        rst1, iv1, ir1, irv1, ie1, dv1, dr1, dwe1, drv1, de1;
    logic [31:0] ia1, ird1, da1, dwd1, drd1;
    logic [3:0]  dst1;
    // DUT with READ_LATENCY=3
    logic        rst3, iv3, ir3, irv3, ie3, dv3, dr3, dwe3, drv3, de3;
    logic [31:0] ia3, ird3, da3, dwd3, drd3;
    logic [3:0]  dst3;

    arb_memory #(.MEMORY_WORDS(MW), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(rst1),
        .ivalid(iv1), .iready(ir1), .iaddr(ia1),
        .irvalid(irv1), .irdata(ird1), .ierr(ie1),
        .dvalid(dv1), .dready(dr1), .dwe(dwe1), .dstrb(dst1), .daddr(da1), .dwdata(dwd1),
        .drvalid(drv1), .drdata(drd1), .derr(de1)
    );

    arb_memory #(.MEMORY_WORDS(MW), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(rst3),
        .ivalid(iv3), .iready(ir3), .iaddr(ia3),
        .irvalid(irv3), .irdata(ird3), .ierr(ie3),
        .dvalid(dv3), .dready(dr3), .dwe(dwe3), .dstrb(dst3), .daddr(da3), .dwdata(dwd3),
        .drvalid(drv3), .drdata(drd3), .derr(de3)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t qi1[$], qd1[$], qi3[$], qd3[$];
    logic [31:0] model1 [int];
    logic [31:0] model3 [int];

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(MW));
    endfunction

    function automatic logic [31:0] model_rd(input int which, input logic [31:0] a);
        int key;
        key = int'(a[31:2]);
        if (which == 1) return model1.exists(key) ? model1[key] : 32'hDEAD_BEEF;
        return model3.exists(key) ? model3[key] : 32'hDEAD_BEEF;
    endfunction

    // Scoreboard push for an accepted fetch.
    task automatic exp_i(input int which, input logic [31:0] a);
        exp_t e;
        e.err  = addr_err(a);
        e.due  = cyc + ((which == 1) ? 1 : 3);
        e.data = e.err ? 32'h0 : model_rd(which, a);
        if (which == 1) qi1.push_back(e);
        else            qi3.push_back(e);
    endtask

    // Scoreboard push for an accepted load/store; stores update the reference RAM.
    task automatic exp_d(input int which, input logic we, input logic [3:0] strb,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] w;
        e.err = addr_err(a);
        e.due = cyc + ((which == 1) ? 1 : 3);
        if (we && !e.err) begin
            w = model_rd(which, a);
            for (int n = 0; n < 4; n++) begin
                if (strb[n]) w[8*n +: 8] = wd[8*n +: 8];
            end
            if (which == 1) model1[int'(a[31:2])] = w;
            else            model3[int'(a[31:2])] = w;
        end
        e.data = (we || e.err) ? 32'h0 : model_rd(which, a);
        if (which == 1) qd1.push_back(e);
        else            qd3.push_back(e);
    endtask

    // Response monitor: pops the scoreboard and checks data, error and exact arrival cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (irv1) begin
            compared++;
            if (qi1.size() == 0) begin
                mismatched++;
                $display("FAIL i1_unexpected_resp cyc=%0d data=%h err=%b", cyc, ird1, ie1);
            end else begin
                e = qi1.pop_front();
                if (e.due != cyc || ird1 !== e.data || ie1 !== e.err) begin
                    mismatched++;
                    $display("FAIL i1_resp cyc=%0d due=%0d data=%h want=%h err=%b want=%b", cyc, e.due, ird1, e.data, ie1, e.err);
                end
            end
        end else if (qi1.size() != 0 && qi1[0].due <= cyc) begin
            compared++; mismatched++;
            $display("FAIL i1_missing_resp cyc=%0d due=%0d", cyc, qi1[0].due);
            void'(qi1.pop_front());
        end
        if (drv1) begin
            compared++;
            if (qd1.size() == 0) begin
                mismatched++;
                $display("FAIL d1_unexpected_resp cyc=%0d data=%h err=%b", cyc, drd1, de1);
            end else begin
                e = qd1.pop_front();
                if (e.due != cyc || drd1 !== e.data || de1 !== e.err) begin
                    mismatched++;
                    $display("FAIL d1_resp cyc=%0d due=%0d data=%h want=%h err=%b want=%b", cyc, e.due, drd1, e.data, de1, e.err);
                end
            end
        end else if (qd1.size() != 0 && qd1[0].due <= cyc) begin
            compared++; mismatched++;
            $display("FAIL d1_missing_resp cyc=%0d due=%0d", cyc, qd1[0].due);
            void'(qd1.pop_front());
        end
        if (irv3) begin
            compared++;
            if (qi3.size() == 0) begin
                mismatched++;
                $display("FAIL i3_unexpected_resp cyc=%0d data=%h err=%b", cyc, ird3, ie3);
            end else begin
                e = qi3.pop_front();
                if (e.due != cyc || ird3 !== e.data || ie3 !== e.err) begin
                    mismatched++;
                    $display("FAIL i3_resp cyc=%0d due=%0d data=%h want=%h err=%b want=%b", cyc, e.due, ird3, e.data, ie3, e.err);
                end
            end
        end else if (qi3.size() != 0 && qi3[0].due <= cyc) begin
            compared++; mismatched++;
            $display("FAIL i3_missing_resp cyc=%0d due=%0d", cyc, qi3[0].due);
            void'(qi3.pop_front());
        end
        if (drv3) begin
            compared++;
            if (qd3.size() == 0) begin
                mismatched++;
                $display("FAIL d3_unexpected_resp cyc=%0d data=%h err=%b", cyc, drd3, de3);
            end else begin
                e = qd3.pop_front();
                if (e.due != cyc || drd3 !== e.data || de3 !== e.err) begin
                    mismatched++;
                    $display("FAIL d3_resp cyc=%0d due=%0d data=%h want=%h err=%b want=%b", cyc, e.due, drd3, e.data, de3, e.err);
                end
            end
        end else if (qd3.size() != 0 && qd3[0].due <= cyc) begin
            compared++; mismatched++;
            $display("FAIL d3_missing_resp cyc=%0d due=%0d", cyc, qd3[0].due);
            void'(qd3.pop_front());
        end
    end

    task automatic test_reset;
        rst1 = 1'b1; rst3 = 1'b1;
        iv1 = 1'b1; dv1 = 1'b1; iv3 = 1'b1; dv3 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if ({ir1, dr1, ir3, dr3} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_ready got=%b want=0000", {ir1, dr1, ir3, dr3});
        end
        compared++;
        if ({irv1, drv1, ie1, de1, irv3, drv3, ie3, de3} !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_resp_flags got=%b want=00000000", {irv1, drv1, ie1, de1, irv3, drv3, ie3, de3});
        end
        compared++;
        if ({ird1, drd1, ird3, drd3} !== 128'h0) begin
            mismatched++;
            $display("FAIL reset_resp_data got=%h %h %h %h want=0", ird1, drd1, ird3, drd3);
        end
        @(negedge clk);
        iv1 = 1'b0; dv1 = 1'b0; iv3 = 1'b0; dv3 = 1'b0;
        rst1 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
    endtask

    // Preload word 4, then a single fetch of it.
    task automatic test_fetch;
        @(negedge clk);
        dv1 = 1'b1; dwe1 = 1'b1; dst1 = 4'hF; da1 = 32'h10; dwd1 = 32'h1122_3344;
        #1;
        compared++;
        if (dr1 !== 1'b1 || ir1 !== 1'b0) begin
            mismatched++;
            $display("FAIL preload_ready dready=%b iready=%b want 1 0", dr1, ir1);
        end
        if (dr1) exp_d(1, 1'b1, 4'hF, 32'h10, 32'h1122_3344);
        @(negedge clk);
        dv1 = 1'b0; iv1 = 1'b1; ia1 = 32'h10;
        #1;
        compared++;
        if (ir1 !== 1'b1) begin
            mismatched++;
            $display("FAIL fetch_iready got=%b want=1", ir1);
        end
        if (ir1) exp_i(1, 32'h10);
        @(negedge clk);
        iv1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Strobed store, immediate load, no-op (dstrb=0) store, load again.
    task automatic test_strobe;
        logic        we   [4];
        logic [3:0]  strb [4];
        logic [31:0] wd   [4];
        we   = '{1'b1, 1'b0, 1'b1, 1'b0};
        strb = '{4'b0101, 4'b0000, 4'b0000, 4'b0000};
        wd   = '{32'hAABB_CCDD, 32'h0, 32'hFFFF_FFFF, 32'h0};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            dv1 = 1'b1; dwe1 = we[k]; dst1 = strb[k]; da1 = 32'h10; dwd1 = wd[k];
            #1;
            compared++;
            if (dr1 !== 1'b1) begin
                mismatched++;
                $display("FAIL strobe_dready step=%0d got=%b want=1", k, dr1);
            end
            if (dr1) exp_d(1, we[k], strb[k], 32'h10, wd[k]);
        end
        @(negedge clk);
        dv1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Both ports valid right after reset: grants alternate i,d,i,d.
    task automatic test_arbitration;
        logic [31:0] ia [4];
        logic [31:0] da [4];
        logic        want_i;
        ia = '{32'h10, 32'h18, 32'h14, 32'h18};
        da = '{32'h18, 32'h14, 32'h18, 32'h10};
        @(negedge clk);
        dv1 = 1'b1; dwe1 = 1'b1; dst1 = 4'hF; da1 = 32'h14; dwd1 = 32'h5566_7788;
        #1;
        compared++;
        if (dr1 !== 1'b1) begin
            mismatched++;
            $display("FAIL arb_setup_dready got=%b want=1", dr1);
        end
        if (dr1) exp_d(1, 1'b1, 4'hF, 32'h14, 32'h5566_7788);
        @(negedge clk);
        dv1 = 1'b0;
        repeat (2) @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            iv1 = 1'b1; dv1 = 1'b1; dwe1 = 1'b0; dst1 = 4'h0; ia1 = ia[k]; da1 = da[k];
            #1;
            want_i = (k % 2 == 0);
            compared++;
            if (ir1 !== want_i || dr1 !== !want_i) begin
                mismatched++;
                $display("FAIL arb_grant step=%0d iready=%b dready=%b want %b %b", k, ir1, dr1, want_i, !want_i);
            end
            if (ir1) exp_i(1, ia[k]);
            if (dr1) exp_d(1, 1'b0, 4'h0, da[k], 32'h0);
        end
        @(negedge clk);
        iv1 = 1'b0; dv1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Misaligned and out-of-range accesses; out-of-range store must not alias into word 0.
    task automatic test_errors;
        logic        we [7];
        logic [31:0] ad [7];
        logic [31:0] wd [7];
        we = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ad = '{32'h0, 32'h12, 32'h0004_0000, 32'h11, 32'h0, 32'h10, 32'hFFFF_FFFC};
        wd = '{32'h0102_0304, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            dv1 = 1'b1; dwe1 = we[k]; dst1 = 4'hF; da1 = ad[k]; dwd1 = wd[k];
            #1;
            compared++;
            if (dr1 !== 1'b1) begin
                mismatched++;
                $display("FAIL err_dready step=%0d got=%b want=1", k, dr1);
            end
            if (dr1) exp_d(1, we[k], 4'hF, ad[k], wd[k]);
        end
        @(negedge clk);
        dv1 = 1'b0; iv1 = 1'b1; ia1 = 32'h0004_0000;
        #1;
        compared++;
        if (ir1 !== 1'b1) begin
            mismatched++;
            $display("FAIL err_fetch_iready got=%b want=1", ir1);
        end
        if (ir1) exp_i(1, 32'h0004_0000);
        @(negedge clk);
        iv1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Eight stores then eight back-to-back loads with ivalid held low.
    task automatic test_back_to_back;
        int          pulses;
        logic [31:0] a;
        logic [31:0] w;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            a = 32'(8 + k) << 2;
            w = (32'h0101_0101 * 32'(k + 1)) ^ 32'hA500_0000;
            dv1 = 1'b1; dwe1 = 1'b1; dst1 = 4'hF; da1 = a; dwd1 = w;
            #1;
            compared++;
            if (dr1 !== 1'b1) begin
                mismatched++;
                $display("FAIL b2b_store_dready step=%0d got=%b want=1", k, dr1);
            end
            if (dr1) exp_d(1, 1'b1, 4'hF, a, w);
        end
        @(negedge clk);
        dv1 = 1'b0;
        repeat (2) @(negedge clk);
        pulses = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (drv1) pulses++;
            if (k < 8) begin
                a = 32'(15 - k) << 2;
                dv1 = 1'b1; dwe1 = 1'b0; dst1 = 4'h0; da1 = a;
                #1;
                compared++;
                if (dr1 !== 1'b1) begin
                    mismatched++;
                    $display("FAIL b2b_load_dready step=%0d got=%b want=1", k, dr1);
                end
                if (dr1) exp_d(1, 1'b0, 4'h0, a, 32'h0);
            end else begin
                dv1 = 1'b0;
            end
        end
        compared++;
        if (pulses !== 8) begin
            mismatched++;
            $display("FAIL b2b_pulse_count got=%0d want=8", pulses);
        end
        repeat (2) @(negedge clk);
    endtask

    // READ_LATENCY=3: latency check, then reset after the second of three fetches drops all of them.
    task automatic test_latency_reset;
        int pulses;
        @(negedge clk);
        dv3 = 1'b1; dwe3 = 1'b1; dst3 = 4'hF; da3 = 32'h8; dwd3 = 32'hCAFE_F00D;
        #1;
        compared++;
        if (dr3 !== 1'b1) begin
            mismatched++;
            $display("FAIL rl3_store_dready got=%b want=1", dr3);
        end
        if (dr3) exp_d(3, 1'b1, 4'hF, 32'h8, 32'hCAFE_F00D);
        @(negedge clk);
        dv3 = 1'b0; iv3 = 1'b1; ia3 = 32'h8;
        #1;
        compared++;
        if (ir3 !== 1'b1) begin
            mismatched++;
            $display("FAIL rl3_fetch_iready got=%b want=1", ir3);
        end
        if (ir3) exp_i(3, 32'h8);
        @(negedge clk);
        iv3 = 1'b0;
        repeat (5) @(negedge clk);

        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            iv3 = 1'b1; ia3 = (k == 0) ? 32'h8 : 32'hC;
            #1;
            compared++;
            if (ir3 !== 1'b1) begin
                mismatched++;
                $display("FAIL rl3_drop_iready step=%0d got=%b want=1", k, ir3);
            end
        end
        pulses = 0;
        @(negedge clk);
        rst3 = 1'b1; ia3 = 32'h8;
        #1;
        compared++;
        if (ir3 !== 1'b0) begin
            mismatched++;
            $display("FAIL rl3_reset_iready got=%b want=0", ir3);
        end
        if (irv3) pulses++;
        @(negedge clk);
        rst3 = 1'b0; iv3 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (irv3) pulses++;
            @(negedge clk);
        end
        compared++;
        if (pulses !== 0) begin
            mismatched++;
            $display("FAIL rl3_dropped_resp got=%0d irvalid pulses want=0", pulses);
        end
    endtask

    initial begin
        rst1 = 1'b1; iv1 = 1'b0; ia1 = 32'h0; dv1 = 1'b0; dwe1 = 1'b0; dst1 = 4'h0; da1 = 32'h0; dwd1 = 32'h0;
        rst3 = 1'b1; iv3 = 1'b0; ia3 = 32'h0; dv3 = 1'b0; dwe3 = 1'b0; dst3 = 4'h0; da3 = 32'h0; dwd3 = 32'h0;

        test_reset();
        test_fetch();
        test_strobe();
        test_arbitration();
        test_errors();
        test_back_to_back();
        test_latency_reset();

        repeat (4) @(negedge clk);
        compared++;
        if (qi1.size() + qd1.size() + qi3.size() + qd3.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain pending=%0d want=0", qi1.size() + qd1.size() + qi3.size() + qd3.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
